// File: rtl/segway_pkg.sv
// segway_pkg: shared command defaults and FSM state types for the Segway BLE front end
package segway_pkg;
  localparam logic [7:0] CMD_GO_DEF = 8'h67;
  localparam logic [7:0] CMD_STOP_DEF = 8'h73;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop RX synchronizer
//   ports: clk, rst (async high), rx (serial in, idle high),
//          rx_data (last good byte), rx_rdy (byte pulse), frm_err (bad stop pulse)
module uart_rx
  import segway_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frm_err
);
  localparam int CW = $clog2(BAUD_DIV + 1);
  rx_state_t st, nst;
  logic rx_m, rx_s, rx_p;
  logic [CW-1:0] cnt;
  logic [3:0] idx;
  logic [7:0] sh;
  logic fall, expire, rdy_nxt, err_nxt;
  // rx_p remembers the previous rx_s so IDLE only starts on a real falling edge
  assign fall = rx_p & ~rx_s;
  // expiry one count early makes each reload span exactly its load value in clocks
  assign expire = cnt == CW'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= nst;
  always_comb begin
    nst = st;
    case (st)
      IDLE: nst = fall ? START : IDLE;
      START: nst = expire ? (rx_s ? IDLE : DATA) : START;
      DATA: nst = (expire && idx == 4'd7) ? STOP : DATA;
      STOP: nst = expire ? IDLE : STOP;
    endcase
  end
  always_comb begin
    rdy_nxt = st == STOP && expire && rx_s;
    err_nxt = st == STOP && expire && !rx_s;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {rx_m, rx_s, rx_p} <= 3'b111;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      rx_data <= '0;
      rx_rdy <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      {rx_m, rx_s, rx_p} <= {rx, rx_m, rx_s};
      cnt <= st == IDLE ? CW'(BAUD_DIV / 2) : expire ? CW'(BAUD_DIV) : cnt - CW'(1);
      idx <= st == START ? 4'd0 : (st == DATA && expire) ? idx + 4'd1 : idx;
      if (st == DATA && expire) sh <= {rx_s, sh[7:1]};
      if (rdy_nxt) rx_data <= sh;
      rx_rdy <= rdy_nxt;
      frm_err <= err_nxt;
    end
endmodule

// File: rtl/ble_auth_rx.sv
// ble_auth_rx: BLE command receiver plus power-up authorization FSM
//   ports: clk, rst (async high), RX (serial from BLE), rider_off (load cell),
//          pwr_up (platform enable), rx_data/rx_rdy/frm_err (receiver status)
module ble_auth_rx
  import segway_pkg::*;
#(
  parameter int BAUD_DIV = 2604,
  parameter logic [7:0] CMD_GO = CMD_GO_DEF,
  parameter logic [7:0] CMD_STOP = CMD_STOP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       rider_off,
  output logic       pwr_up,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frm_err
);
  auth_state_t st, nst;
  logic go, stop, pwr_nxt;
  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk(clk),
    .rst(rst),
    .rx(RX),
    .rx_data(rx_data),
    .rx_rdy(rx_rdy),
    .frm_err(frm_err)
  );
  assign go = rx_rdy && rx_data == CMD_GO;
  assign stop = rx_rdy && rx_data == CMD_STOP;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= OFF;
      pwr_up <= 1'b0;
    end else begin
      st <= nst;
      pwr_up <= pwr_nxt;
    end
  // PWR2 waits for the rider to step off; a fresh go overrides that exit
  always_comb begin
    nst = st;
    case (st)
      OFF: nst = go ? PWR1 : OFF;
      PWR1: nst = stop ? (rider_off ? OFF : PWR2) : PWR1;
      PWR2: nst = go ? PWR1 : rider_off ? OFF : PWR2;
      default: nst = OFF;
    endcase
  end
  always_comb pwr_nxt = nst != OFF;
endmodule

// File: tb/tb_ble_auth_rx.sv
// tb_ble_auth_rx: self-checking bench for ble_auth_rx (vector table, corner sequences, random bytes vs model)
module tb_ble_auth_rx;
  localparam int B = 16;
  typedef struct {
    logic [7:0] d;
    logic stop;
    logic ro;
    logic [7:0] xd;
    logic xp;
    logic xr;
  } vec_t;
  logic clk = 0, rst = 1, rx = 1, rider_off = 0;
  logic pwr_up, rx_rdy, frm_err;
  logic [7:0] rx_data;
  int total = 0, bad = 0, cyc = 0, rdy_cnt = 0, err_cnt = 0;
  int rdy_t[$];
  logic pwr_pre = 0, pwr_post = 0, post_pend = 0;
  vec_t tbl[9];
  ble_auth_rx #(.BAUD_DIV(B)) dut (
    .clk(clk),
    .rst(rst),
    .RX(rx),
    .rider_off(rider_off),
    .pwr_up(pwr_up),
    .rx_data(rx_data),
    .rx_rdy(rx_rdy),
    .frm_err(frm_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (post_pend) begin
      pwr_post = pwr_up;
      post_pend = 0;
    end
    if (rx_rdy) begin
      rdy_cnt++;
      rdy_t.push_back(cyc);
      pwr_pre = pwr_up;
      post_pend = 1;
    end
    if (frm_err) err_cnt++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic stop);
    rx = 0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (B) @(negedge clk);
    end
    rx = stop;
    repeat (B) @(negedge clk);
    rx = 1;
  endtask
  initial begin
    int r0, e0;
    logic [7:0] d, xd;
    logic ro, st, xp, powered, pending;
    tbl[0] = '{8'h67, 1, 0, 8'h67, 1, 1};
    tbl[1] = '{8'h73, 1, 0, 8'h73, 1, 1};
    tbl[2] = '{8'h67, 1, 1, 8'h67, 1, 1};
    tbl[3] = '{8'h73, 1, 1, 8'h73, 0, 1};
    tbl[4] = '{8'h41, 1, 1, 8'h41, 0, 1};
    tbl[5] = '{8'h67, 1, 0, 8'h67, 1, 1};
    tbl[6] = '{8'h55, 0, 0, 8'h67, 1, 0};
    tbl[7] = '{8'h73, 0, 0, 8'h67, 1, 0};
    tbl[8] = '{8'h41, 1, 0, 8'h41, 1, 1};
    repeat (3) @(negedge clk);
    chk("rst_pwr_up", pwr_up, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_rdy", rx_rdy, 0);
    chk("rst_frm_err", frm_err, 0);
    rst = 0;
    repeat (3) @(negedge clk);
    xp = 0;
    for (int i = 0; i < 9; i++) begin
      rider_off = tbl[i].ro;
      r0 = rdy_cnt;
      e0 = err_cnt;
      send(tbl[i].d, tbl[i].stop);
      repeat (4) @(negedge clk);
      chk($sformatf("v%0d_rdy", i), rdy_cnt - r0, {31'd0, tbl[i].xr});
      chk($sformatf("v%0d_err", i), err_cnt - e0, {31'd0, !tbl[i].xr});
      chk($sformatf("v%0d_data", i), rx_data, tbl[i].xd);
      chk($sformatf("v%0d_pwr", i), pwr_up, tbl[i].xp);
      if (tbl[i].xr) begin
        chk($sformatf("v%0d_pwr_at_rdy", i), pwr_pre, xp);
        chk($sformatf("v%0d_pwr_after_rdy", i), pwr_post, tbl[i].xp);
      end
      xp = tbl[i].xp;
      if (i == 1) begin
        rider_off = 1;
        chk("pwr2_hold", pwr_up, 1);
        @(negedge clk);
        chk("pwr2_rider_off", pwr_up, 0);
        xp = 0;
      end
    end
    rider_off = 0;
    r0 = rdy_cnt;
    e0 = err_cnt;
    rx = 0;
    repeat (B / 4) @(negedge clk);
    rx = 1;
    repeat (2 * B) @(negedge clk);
    chk("glitch_rdy", rdy_cnt - r0, 0);
    chk("glitch_err", err_cnt - e0, 0);
    send(8'h67, 1);
    repeat (4) @(negedge clk);
    chk("after_glitch_rdy", rdy_cnt - r0, 1);
    chk("after_glitch_data", rx_data, 8'h67);
    chk("after_glitch_pwr", pwr_up, 1);
    r0 = rdy_cnt;
    e0 = err_cnt;
    fork
      send(8'h67, 1);
      begin
        repeat (5 * B + B / 2) @(negedge clk);
        rst = 1;
        #1 chk("midrst_pwr", pwr_up, 0);
      end
    join
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("midrst_rdy", rdy_cnt - r0, 0);
    chk("midrst_err", err_cnt - e0, 0);
    chk("midrst_data", rx_data, 0);
    rdy_t.delete();
    send(8'h67, 1);
    send(8'h73, 1);
    repeat (4) @(negedge clk);
    chk("b2b_count", rdy_t.size(), 2);
    if (rdy_t.size() == 2) chk("b2b_spacing", rdy_t[1] - rdy_t[0], 10 * B);
    chk("b2b_data", rx_data, 8'h73);
    chk("b2b_pwr", pwr_up, 1);
    xd = 8'h73;
    powered = 1;
    pending = 1;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0: d = 8'h67;
        1: d = 8'h73;
        default: d = 8'($urandom);
      endcase
      ro = 1'($urandom_range(0, 1));
      st = $urandom_range(0, 7) != 0;
      rider_off = ro;
      if (pending && ro) begin
        powered = 0;
        pending = 0;
      end
      r0 = rdy_cnt;
      e0 = err_cnt;
      send(d, st);
      if (st) begin
        xd = d;
        if (d == 8'h67) begin
          powered = 1;
          pending = 0;
        end else if (d == 8'h73 && powered && !pending) begin
          powered = !ro;
          pending = !ro;
        end
      end
      repeat (4) @(negedge clk);
      chk($sformatf("r%0d_rdy", i), rdy_cnt - r0, {31'd0, st});
      chk($sformatf("r%0d_err", i), err_cnt - e0, {31'd0, !st});
      chk($sformatf("r%0d_data", i), rx_data, xd);
      chk($sformatf("r%0d_pwr", i), pwr_up, powered);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
